time_set_ctrl: RTL

// - Downstream consumer of key_long_short: key press events -> time-of-day counters + set-mode FSM.
// - Keeps hh:mm:ss (24 h) from a 1 Hz tick; long press cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
// - Short press increments the field being set. Outputs drive the display/BCD stage.

---
 rtl/time_set_ctrl_if.sv | 29 ++
 rtl/time_set_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if
// Groups the tick/key inputs and the time/mode outputs of time_set_ctrl.
//   tick_1hz         1  one-cycle strobe, once per second
//   key_press_short  1  short-press indication (pulse or level)
//   key_press_long   1  long-press indication (pulse or level)
//   hours            5  0..23, binary
//   minutes          6  0..59, binary
//   seconds          6  0..59, binary
//   mode             2  00 RUN, 01 SET_HOUR, 10 SET_MIN
// Modports: slave = the time_set_ctrl block, master = the key/tick source and display side.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       key_press_short;
    logic       key_press_long;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;

    modport slave (
        input  tick_1hz, key_press_short, key_press_long,
        output hours, minutes, seconds, mode
    );

    modport master (
        output tick_1hz, key_press_short, key_press_long,
        input  hours, minutes, seconds, mode
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Time-of-day keeper (hh:mm:ss, 24 h) with a key-driven set mode.
// A long press cycles RUN -> SET_HOUR -> SET_MIN -> RUN; a short press
// increments the field being edited. Time is frozen while editing and
// seconds are cleared when leaving SET_MIN.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of time_set_ctrl_if (tick/key inputs, time/mode outputs)
// Parameters:
//   TIMEOUT_SEC  idle seconds in a set state before auto-return to RUN
// Configuration:
//   SET_TIMEOUT_EN  when defined, enables the set-mode idle timeout;
//                   otherwise set states are held indefinitely.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic           clk,
    input  logic           rst,
    time_set_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] hours_q, hours_nxt;
    logic [5:0] minutes_q, minutes_nxt;
    logic [5:0] seconds_q, seconds_nxt;
    logic       short_q, long_q;
    logic       ev_s, ev_l;

    if (TIMEOUT_SEC == 0) begin : g_bad_timeout
        $error("TIMEOUT_SEC must be at least 1");
    end

`ifdef SET_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_SEC + 1);
    logic [IDLE_W-1:0] idle_q, idle_nxt;
`endif

    always_comb begin
        ev_s        = bus.key_press_short & ~short_q;
        ev_l        = bus.key_press_long  & ~long_q;
        state_nxt   = state;
        hours_nxt   = hours_q;
        minutes_nxt = minutes_q;
        seconds_nxt = seconds_q;

        unique case (state)
            RUN: begin
                if (bus.tick_1hz) begin
                    if (seconds_q == 6'd59) begin
                        seconds_nxt = '0;
                        if (minutes_q == 6'd59) begin
                            minutes_nxt = '0;
                            hours_nxt   = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
                        end else begin
                            minutes_nxt = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_nxt = seconds_q + 6'd1;
                    end
                end
                if (ev_l) state_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                if (ev_l)      state_nxt = SET_MIN;
                else if (ev_s) hours_nxt = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
            end
            SET_MIN: begin
                if (ev_l) begin
                    state_nxt   = RUN;
                    seconds_nxt = '0;
                end else if (ev_s) begin
                    minutes_nxt = (minutes_q == 6'd59) ? '0 : minutes_q + 6'd1;
                end
            end
            default: state_nxt = RUN;
        endcase

`ifdef SET_TIMEOUT_EN
        // Timeout overrides any key event in the same cycle: the edit made so
        // far is kept but a concurrent short-press increment is discarded.
        idle_nxt = idle_q;
        if (state == RUN) begin
            idle_nxt = '0;
        end else if (bus.tick_1hz && idle_q == IDLE_W'(TIMEOUT_SEC - 1)) begin
            state_nxt   = RUN;
            seconds_nxt = '0;
            hours_nxt   = hours_q;
            minutes_nxt = minutes_q;
            idle_nxt    = '0;
        end else if (ev_s || ev_l) begin
            idle_nxt = '0;
        end else if (bus.tick_1hz) begin
            idle_nxt = idle_q + IDLE_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
`ifdef SET_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            hours_q   <= hours_nxt;
            minutes_q <= minutes_nxt;
            seconds_q <= seconds_nxt;
            short_q   <= bus.key_press_short;
            long_q    <= bus.key_press_long;
`ifdef SET_TIMEOUT_EN
            idle_q    <= idle_nxt;
`endif
        end
    end

    assign bus.hours   = hours_q;
    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.mode    = state;

endmodule
